collision_monitor: RTL
======================

# collision_monitor

Parametrised collision detector and game-state controller for the VGA runner game. It samples per-pixel obstacle coverage flags and character-part coverage flags on every pixel strobe and accumulates overlap over each video frame. At end of frame it decides whether the player has lost, so a single stray pixel no longer resets the game. It sits between the obstacle/character pixel decoders and the animation, score and reset logic, and replaces the combinational `any_obj && any_char` reset path with a registered state machine.

## Interface
- `N_OBS`, 8, number of obstacle coverage channels.
- `N_PART`, 6, number of character-part coverage channels.
- `HIT_FRAMES`, 2, consecutive overlapping frames required to declare a loss; legal range 1..15.
- `FRAME_W`, 16, width of the survival-frame counter.

- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_pix_stb`  in  1  pixel strobe; coverage inputs are valid only when high.
- `i_frame_end`  in  1  single-cycle end-of-frame pulse (animate).
- `i_obs`  in  N_OBS  obstacle coverage of current pixel, one bit per obstacle.
- `i_part`  in  N_PART  character-part coverage of current pixel.
- `i_part_mask`  in  N_PART  1 = part is collidable; masked parts never cause hits.
- `i_pause`  in  1  level; high requests pause.
- `i_start`  in  1  single-cycle pulse; starts a game from IDLE or LOST.
- `o_state`  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 LOST.
- `o_run`  out  1  high only in RUN; gates obstacle and character animation.
- `o_lose_pulse`  out  1  one-cycle pulse on entry to LOST.
- `o_hit_obs`  out  N_OBS  obstacles that overlapped during the losing frame.
- `o_hit_part`  out  N_PART  parts that overlapped during the losing frame.
- `o_frames`  out  FRAME_W  frames survived in the current game, saturating.

## Operation
- Overlap is defined as: `i_pix_stb` high AND |`i_obs` AND |(`i_part` & `i_part_mask`).
- Accumulation happens in RUN only:
  - `frame_hit` is set on any overlap.
  - `obs_acc` ORs in `i_obs` on overlap cycles.
  - `part_acc` ORs in `i_part & i_part_mask` on overlap cycles.
- End-of-frame evaluation, on `i_frame_end` while in RUN:
  - The frame's hit value is `frame_hit` OR the overlap on the same cycle. A simultaneous overlap counts toward the ending frame.
  - If the frame is a hit, `hit_cnt` increments; otherwise `hit_cnt` clears to 0.
  - If the incremented `hit_cnt` ≥ HIT_FRAMES: go to LOST, latch the accumulators (including the same-cycle contribution) into `o_hit_obs`/`o_hit_part`, and pulse `o_lose_pulse`.
  - Otherwise, `o_frames` increments, saturating at all-ones.
  - In all cases, `frame_hit`, `obs_acc` and `part_acc` clear.
- `hit_cnt` is 4 bits.
- FSM transitions, in priority order:
  - IDLE: `i_start` → RUN. Clears `o_frames`, `hit_cnt`, accumulators, `o_hit_obs` and `o_hit_part`.
  - RUN: loss at end of frame → LOST. Else `i_pause` high → PAUSE. Loss takes priority over pause on the same cycle.
  - PAUSE: `i_pause` low → RUN. Accumulators, `hit_cnt` and `o_frames` hold. `i_frame_end` and coverage inputs are ignored. `i_start` is ignored.
  - LOST: `i_start` → RUN, with the same clears as from IDLE. `i_pause` is ignored. `o_hit_*` hold until the restart.
- `i_start` while in RUN is ignored.

## Timing
- All outputs are registered and change on the `i_clk` edge following the causing input.
- `o_state`, `o_run`, `o_lose_pulse` and `o_hit_*` update one cycle after the `i_frame_end` cycle.
- `o_lose_pulse` is high for exactly one cycle.
- Pause entry and exit take effect one cycle after the `i_pause` level change.
- Reset (`i_rst_n` low, asynchronous, mid-frame or mid-game) forces:
  - `o_state` = IDLE; `o_run` = 0; `o_lose_pulse` = 0.
  - `o_hit_obs` = 0; `o_hit_part` = 0; `o_frames` = 0.
  - `hit_cnt` and all accumulators = 0.
- Reset deassertion takes effect at the next `i_clk` edge; no partial-frame state survives.
- Coverage inputs sampled while `i_pix_stb` is low are ignored, including on an `i_frame_end` cycle.

## Test plan
- **Reset and start.** Hold `i_rst_n` low, release, pulse `i_start`. Require: `o_state` 00 → 01, `o_run` = 1, `o_frames` = 0. Three clean frames give `o_frames` = 3.
- **Single-frame glitch.** HIT_FRAMES = 2. Overlap `i_obs` = 8'h04 with `i_part` = 6'h01 in one frame only, then a clean frame. Require: no LOST, `o_frames` increments both frames, `hit_cnt` returns to 0.
- **Sustained hit.** Overlap `i_obs` = 8'h81, `i_part` = 6'h06 in two consecutive frames. Require:
  - `o_state` = 11 and `o_lose_pulse` high for one cycle after the second `i_frame_end`.
  - `o_hit_obs` = 8'h81, `o_hit_part` = 6'h06.
  - `o_frames` unchanged after the first hit frame's increment.
- **Masked part.** `i_part_mask` = 6'h3E, overlap only on part 0, for 5 frames. Require: RUN is held, `o_frames` = 5.
- **Pause.** Raise `i_pause` mid-frame after one overlap pixel. Pulse `i_frame_end` 3 times during pause. Drop `i_pause`. Require: `o_state` = 10 during pause, `o_frames` held. The first `i_frame_end` after resume counts the retained hit.
- **Same-cycle boundary.** Overlap only on the `i_frame_end` cycle with `i_pix_stb` = 1, HIT_FRAMES = 1. Require: LOST with that obstacle latched. Repeat with `i_pix_stb` = 0: require no LOST.

Source files
------------

// File: rtl/collision_monitor.sv
// collision_monitor
// Frame-accumulating collision detector and game-state controller for the
// VGA runner game. Overlap between obstacle and collidable character pixels
// is gathered over a whole video frame and judged at end of frame, so a
// single stray pixel cannot end the game on its own. A loss needs HIT_FRAMES
// overlapping frames in a row. All outputs are registered.

module collision_monitor #(
    parameter int N_OBS      = 8,
    parameter int N_PART     = 6,
    parameter int HIT_FRAMES = 2,
    parameter int FRAME_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pix_stb,
    input  logic               i_frame_end,
    input  logic [N_OBS-1:0]   i_obs,
    input  logic [N_PART-1:0]  i_part,
    input  logic [N_PART-1:0]  i_part_mask,
    input  logic               i_pause,
    input  logic               i_start,
    output logic [1:0]         o_state,
    output logic               o_run,
    output logic               o_lose_pulse,
    output logic [N_OBS-1:0]   o_hit_obs,
    output logic [N_PART-1:0]  o_hit_part,
    output logic [FRAME_W-1:0] o_frames
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LOST  = 2'b11
    } state_t;

    // hit_cnt is compared in 5 bits so the increment can never wrap
    localparam logic [4:0]         HIT_LIM    = 5'(HIT_FRAMES);
    localparam logic [FRAME_W-1:0] FRAMES_MAX = {FRAME_W{1'b1}};
    localparam logic [FRAME_W-1:0] FRAMES_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

    state_t              state_q,     state_d;
    logic                run_q,       run_d;
    logic                lose_q,      lose_d;
    logic [N_OBS-1:0]    hit_obs_q,   hit_obs_d;
    logic [N_PART-1:0]   hit_part_q,  hit_part_d;
    logic [FRAME_W-1:0]  frames_q,    frames_d;
    logic [3:0]          hit_cnt_q,   hit_cnt_d;
    logic                frame_hit_q, frame_hit_d;
    logic [N_OBS-1:0]    obs_acc_q,   obs_acc_d;
    logic [N_PART-1:0]   part_acc_q,  part_acc_d;

    logic [N_PART-1:0]   part_live;
    logic                overlap;
    logic                frame_is_hit;
    logic [4:0]          hit_cnt_inc;
    logic [N_OBS-1:0]    obs_now;
    logic [N_PART-1:0]   part_now;

    // Per-pixel overlap and the same-cycle contribution folded into the frame
    always_comb begin
        part_live    = i_part & i_part_mask;
        overlap      = i_pix_stb && (|i_obs) && (|part_live);
        obs_now      = overlap ? i_obs     : '0;
        part_now     = overlap ? part_live : '0;
        frame_is_hit = frame_hit_q | overlap;
        hit_cnt_inc  = {1'b0, hit_cnt_q} + 5'd1;
    end

    // Next-state and next-output logic; everything holds unless changed below
    always_comb begin
        state_d     = state_q;
        lose_d      = 1'b0;
        hit_obs_d   = hit_obs_q;
        hit_part_d  = hit_part_q;
        frames_d    = frames_q;
        hit_cnt_d   = hit_cnt_q;
        frame_hit_d = frame_hit_q;
        obs_acc_d   = obs_acc_q;
        part_acc_d  = part_acc_q;

        case (state_q)
            ST_IDLE, ST_LOST: begin
                if (i_start) begin
                    state_d     = ST_RUN;
                    frames_d    = '0;
                    hit_cnt_d   = '0;
                    frame_hit_d = 1'b0;
                    obs_acc_d   = '0;
                    part_acc_d  = '0;
                    hit_obs_d   = '0;
                    hit_part_d  = '0;
                end
            end

            ST_RUN: begin
                frame_hit_d = frame_hit_q | overlap;
                obs_acc_d   = obs_acc_q   | obs_now;
                part_acc_d  = part_acc_q  | part_now;

                if (i_frame_end) begin
                    hit_cnt_d   = frame_is_hit ? hit_cnt_inc[3:0] : 4'd0;
                    frame_hit_d = 1'b0;
                    obs_acc_d   = '0;
                    part_acc_d  = '0;
                    if (frame_is_hit && (hit_cnt_inc >= HIT_LIM)) begin
                        state_d    = ST_LOST;
                        lose_d     = 1'b1;
                        hit_obs_d  = obs_acc_q  | obs_now;
                        hit_part_d = part_acc_q | part_now;
                    end else begin
                        if (frames_q != FRAMES_MAX) begin
                            frames_d = frames_q + FRAMES_ONE;
                        end
                        if (i_pause) begin
                            state_d = ST_PAUSE;
                        end
                    end
                end else if (i_pause) begin
                    state_d = ST_PAUSE;
                end
            end

            ST_PAUSE: begin
                if (!i_pause) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        run_d = (state_d == ST_RUN);
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            run_q       <= 1'b0;
            lose_q      <= 1'b0;
            hit_obs_q   <= '0;
            hit_part_q  <= '0;
            frames_q    <= '0;
            hit_cnt_q   <= '0;
            frame_hit_q <= 1'b0;
            obs_acc_q   <= '0;
            part_acc_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            lose_q      <= lose_d;
            hit_obs_q   <= hit_obs_d;
            hit_part_q  <= hit_part_d;
            frames_q    <= frames_d;
            hit_cnt_q   <= hit_cnt_d;
            frame_hit_q <= frame_hit_d;
            obs_acc_q   <= obs_acc_d;
            part_acc_q  <= part_acc_d;
        end
    end

    assign o_state      = state_q;
    assign o_run        = run_q;
    assign o_lose_pulse = lose_q;
    assign o_hit_obs    = hit_obs_q;
    assign o_hit_part   = hit_part_q;
    assign o_frames     = frames_q;

endmodule
